// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Purpose  : Parametrised N-to-1 valid/ready stream multiplexer. A
//            packet-locked round-robin arbiter picks one input channel, and
//            that channel's beats pass through a single registered output
//            stage until its end-of-packet beat has transferred.
// Options  : STREAM_MUX_MANUAL_SEL_EN adds manual_en / manual_sel. They force
//            arbitration onto one channel and freeze the round-robin pointer
//            for packets granted that way.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel,
`ifdef STREAM_MUX_MANUAL_SEL_EN
    input  logic                      manual_en,
    input  logic [SEL_W-1:0]          manual_sel,
`endif
    input  logic                      out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(CHANNELS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_grant;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [SEL_W-1:0] r_out_sel;

    logic [WIDTH-1:0] w_ch_data [CHANNELS];
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_arb_hit;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_locked;
    logic             w_can_load;
    logic             w_take;
    logic             w_take_last;
    logic             w_ptr_adv;

    // Split the flat data bus into one word per channel so the grant index
    // selects a whole word; ungranted words never reach the output register.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first valid channel at or after ptr, wrapping at
    // CHANNELS (which need not be a power of two).
    always_comb begin
        int j;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        j        = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = int'(r_ptr) + k;
            if (j >= CHANNELS) begin
                j = j - CHANNELS;
            end
            if (!w_rr_hit && in_valid[SEL_W'(j)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = SEL_W'(j);
            end
        end
    end

`ifdef STREAM_MUX_MANUAL_SEL_EN
    logic r_manual;
    logic w_man_ok;

    // Manual mode only ever grants the requested channel, and only if it is
    // in range and currently valid.
    assign w_man_ok  = (int'(manual_sel) < CHANNELS);
    assign w_arb_hit = manual_en ? (w_man_ok && in_valid[manual_sel]) : w_rr_hit;
    assign w_arb_idx = manual_en ? manual_sel : w_rr_idx;
    assign w_ptr_adv = w_take_last && !r_manual;
`else
    assign w_arb_hit = w_rr_hit;
    assign w_arb_idx = w_rr_idx;
    assign w_ptr_adv = w_take_last;
`endif

    // The output register can accept a new beat when it is empty or draining.
    assign w_locked    = (r_state == ST_LOCKED);
    assign w_can_load  = !r_out_valid || out_ready;
    assign w_take      = w_locked && w_can_load && in_valid[r_grant];
    assign w_take_last = w_take && in_last[r_grant];

    // Only the granted channel sees ready, and only while locked.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_locked && w_can_load && (r_grant == SEL_W'(i));
        end
    end

    // Next-state: arbitrate in IDLE, release the lock on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_take_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the grant at arbitration; advance the pointer past the channel
    // whose packet just ended so it goes to the back of the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant  <= '0;
            r_ptr    <= '0;
`ifdef STREAM_MUX_MANUAL_SEL_EN
            r_manual <= 1'b0;
`endif
        end else begin
            if ((r_state == ST_IDLE) && w_arb_hit) begin
                r_grant  <= w_arb_idx;
`ifdef STREAM_MUX_MANUAL_SEL_EN
                r_manual <= manual_en;
`endif
            end
            if (w_ptr_adv) begin
                r_ptr <= (r_grant == c_last_ch) ? '0 : r_grant + 1'b1;
            end
        end
    end

    // Output stage: load on an input transfer, otherwise drop valid once the
    // consumer has taken the beat; payload holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch_data[r_grant];
            r_out_last  <= in_last[r_grant];
            r_out_sel   <= r_grant;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Purpose  : Self-checking bench for stream_mux_rr. Two instances run side by
//            side (4 channels and 3 channels) against a behavioural model,
//            with a vector table, directed packet sequences and random
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]  vin  [2];
    logic [31:0] din  [2];
    logic [3:0]  lin  [2];
    logic        ordy [2];

    logic [3:0] rdy4;
    logic [2:0] rdy3;
    logic [7:0] od4, od3;
    logic       ov4, ov3, ol4, ol3;
    logic [1:0] os4, os3;

    logic [3:0] obs_rdy [2];
    logic [7:0] obs_od  [2];
    logic       obs_ov  [2];
    logic       obs_ol  [2];
    logic [1:0] obs_os  [2];

    assign obs_rdy[0] = rdy4;
    assign obs_rdy[1] = {1'b0, rdy3};
    assign obs_od[0]  = od4;
    assign obs_od[1]  = od3;
    assign obs_ov[0]  = ov4;
    assign obs_ov[1]  = ov3;
    assign obs_ol[0]  = ol4;
    assign obs_ol[1]  = ol3;
    assign obs_os[0]  = os4;
    assign obs_os[1]  = os3;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (din[0]),
        .in_valid  (vin[0]),
        .in_last   (lin[0]),
        .in_ready  (rdy4),
        .out_data  (od4),
        .out_valid (ov4),
        .out_last  (ol4),
        .out_sel   (os4),
        .out_ready (ordy[0])
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (din[1][23:0]),
        .in_valid  (vin[1][2:0]),
        .in_last   (lin[1][2:0]),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_last  (ol3),
        .out_sel   (os3),
        .out_ready (ordy[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit         locked;
        int         grant;
        int         ptr;
        bit         ov;
        logic [7:0] od;
        bit         ol;
        int         os;
    } mdl_t;

    mdl_t m [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  src_q [8][$];   // {last, data}, index dut*4+channel
    logic [15:0] got_q [2][$];   // consumed output beats
    logic [15:0] exp_q [$];
    bit manual_drive = 0;
    bit gap_en       = 0;

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.locked = 0; r.grant = 0; r.ptr = 0;
        r.ov = 0; r.od = 8'h00; r.ol = 0; r.os = 0;
        return r;
    endfunction

    // One clock of the arbiter rules: choose a packet source when unlocked,
    // stream it beat by beat, release after its last beat.
    function automatic mdl_t mdl_step(mdl_t s, int n, logic [3:0] v, logic [31:0] dat,
                                      logic [3:0] lst, bit rdy);
        mdl_t r;
        bit   found;
        r = s;
        found = 0;
        if (!s.locked) begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (s.ptr + k) % n;
                if (!found && v[c] === 1'b1) begin
                    found = 1; r.locked = 1; r.grant = c;
                end
            end
            if (s.ov && rdy) r.ov = 0;
        end else if ((!s.ov || rdy) && v[s.grant] === 1'b1) begin
            r.ov = 1;
            r.od = dat[s.grant*8 +: 8];
            r.ol = lst[s.grant];
            r.os = s.grant;
            if (lst[s.grant] === 1'b1) begin
                r.locked = 0;
                r.ptr    = (s.grant + 1) % n;
            end
        end else if (s.ov && rdy) begin
            r.ov = 0;
        end
        return r;
    endfunction

    function automatic logic [3:0] mdl_ready(mdl_t s, bit rdy);
        logic [3:0] r;
        r = 4'b0000;
        if (s.locked && (!s.ov || rdy)) r[s.grant] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] pk(logic [1:0] s, logic l, logic [7:0] dd);
        return {s, 5'b00000, l, dd};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int d, int c, int nbeats, logic [7:0] base);
        for (int b = 0; b < nbeats; b++) begin
            src_q[d*4+c].push_back({(b == nbeats - 1) ? 1'b1 : 1'b0, 8'(base + b)});
        end
    endtask

    // Producers present the head of their queue; idle lanes carry X.
    task automatic drive();
        if (manual_drive) return;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < nch(d) && src_q[d*4+c].size() > 0 &&
                    (!gap_en || $urandom_range(4, 0) != 0)) begin
                    vin[d][c]        = 1'b1;
                    din[d][c*8 +: 8] = src_q[d*4+c][0][7:0];
                    lin[d][c]        = src_q[d*4+c][0][8];
                end else begin
                    vin[d][c]        = 1'b0;
                    din[d][c*8 +: 8] = 8'hxx;
                    lin[d][c]        = 1'bx;
                end
            end
        end
    endtask

    // One clock: check ready before the edge, step the model, check the
    // registered outputs after the edge, then advance the producers.
    task automatic cycle();
        mdl_t       nx  [2];
        logic [3:0] pop [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d in_ready", d), obs_rdy[d], mdl_ready(m[d], ordy[d]));
            if (obs_ov[d] && ordy[d]) got_q[d].push_back(pk(obs_os[d], obs_ol[d], obs_od[d]));
            pop[d] = obs_rdy[d] & vin[d];
            nx[d]  = mdl_step(m[d], nch(d), vin[d], din[d], lin[d], ordy[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m[d] = nx[d];
            check($sformatf("dut%0d out_valid", d), obs_ov[d], m[d].ov);
            check($sformatf("dut%0d out_data", d),  obs_od[d], m[d].od);
            check($sformatf("dut%0d out_last", d),  obs_ol[d], m[d].ol);
            check($sformatf("dut%0d out_sel", d),   obs_os[d], m[d].os);
            for (int c = 0; c < 4; c++) begin
                if (pop[d][c] && src_q[d*4+c].size() > 0) void'(src_q[d*4+c].pop_front());
            end
        end
        drive();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Assert reset between edges and verify the outputs clear without a clock.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset out_valid", d), obs_ov[d], 0);
            check($sformatf("dut%0d reset out_data", d),  obs_od[d], 0);
            check($sformatf("dut%0d reset out_last", d),  obs_ol[d], 0);
            check($sformatf("dut%0d reset out_sel", d),   obs_os[d], 0);
            check($sformatf("dut%0d reset in_ready", d),  obs_rdy[d], 0);
            m[d] = mdl_reset();
            got_q[d].delete();
        end
        for (int q = 0; q < 8; q++) src_q[q].delete();
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_got(int d, string tag);
        check({tag, " beat count"}, got_q[d].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q[d].size(); i++) begin
            check($sformatf("%s beat %0d", tag, i), got_q[d][i], exp_q[i]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // All channels always valid with single-beat packets: one grant per
        // two clocks, rotating 0,1,2,3,0,1.
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[10] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};

        reset   = 1'b1;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        m[0] = mdl_reset();
        m[1] = mdl_reset();
        drive();
        #6;
        do_reset();

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle out_valid", ov4, 0);
            check("idle in_ready", rdy4, 0);
            check("idle out_sel", os4, 0);
        end

        // Round-robin fairness table.
        do_reset();
        manual_drive = 1;
        vin[1] = 4'h0;
        din[1] = 32'hxxxxxxxx;
        lin[1] = 4'hx;
        for (int i = 0; i < 12; i++) begin
            vin[0]  = tbl[i].valid;
            lin[0]  = tbl[i].last;
            din[0]  = 32'h13121110;
            ordy[0] = tbl[i].ordy;
            #1;
            check($sformatf("rr vec %0d in_ready", i), rdy4, tbl[i].exp_rdy);
            cycle();
            check($sformatf("rr vec %0d out_valid", i), ov4, tbl[i].exp_ov);
            check($sformatf("rr vec %0d out_sel", i), os4, tbl[i].exp_sel);
            check($sformatf("rr vec %0d out_data", i), od4, tbl[i].exp_data);
        end
        manual_drive = 0;
        ordy[0] = 1'b1;

        // Packet lock: ch2 keeps the grant over ch0, then ch3 before ch0.
        do_reset();
        push(0, 1, 1, 8'h51);
        drive();
        run(4);
        push(0, 2, 3, 8'hA1);
        push(0, 0, 2, 8'hB1);
        push(0, 3, 1, 8'hC1);
        drive();
        run(20);
        exp_q = '{pk(2'd1, 1'b1, 8'h51), pk(2'd2, 1'b0, 8'hA1), pk(2'd2, 1'b0, 8'hA2),
                  pk(2'd2, 1'b1, 8'hA3), pk(2'd3, 1'b1, 8'hC1), pk(2'd0, 1'b0, 8'hB1),
                  pk(2'd0, 1'b1, 8'hB2)};
        check_got(0, "lock");

        // Backpressure mid-packet.
        do_reset();
        push(0, 1, 4, 8'hD1);
        drive();
        run(3);
        ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall out_valid", ov4, 1);
            check("stall out_data", od4, 8'hD2);
            check("stall out_last", ol4, 0);
            check("stall out_sel", os4, 1);
            check("stall in_ready", rdy4, 0);
        end
        ordy[0] = 1'b1;
        drive();
        run(10);
        exp_q = '{pk(2'd1, 1'b0, 8'hD1), pk(2'd1, 1'b0, 8'hD2), pk(2'd1, 1'b0, 8'hD3),
                  pk(2'd1, 1'b1, 8'hD4)};
        check_got(0, "backpressure");

        // Reset mid-packet; arbitration restarts from ch0.
        do_reset();
        push(0, 1, 1, 8'h51);
        drive();
        run(4);
        push(0, 2, 4, 8'hE1);
        drive();
        run(2);
        do_reset();
        push(0, 2, 1, 8'hF2);
        push(0, 0, 1, 8'hF0);
        drive();
        run(10);
        exp_q = '{pk(2'd0, 1'b1, 8'hF0), pk(2'd2, 1'b1, 8'hF2)};
        check_got(0, "post-reset");

        // Three-channel wrap: after ch2's last beat, ch0 wins over ch1.
        do_reset();
        push(1, 2, 1, 8'h32);
        drive();
        run(1);
        push(1, 0, 1, 8'h30);
        push(1, 1, 1, 8'h31);
        drive();
        run(10);
        exp_q = '{pk(2'd2, 1'b1, 8'h32), pk(2'd0, 1'b1, 8'h30), pk(2'd1, 1'b1, 8'h31)};
        check_got(1, "wrap3");

        // Random traffic on both instances against the model.
        do_reset();
        gap_en = 1;
        for (int t = 0; t < 2000; t++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < nch(d); c++) begin
                    if (src_q[d*4+c].size() == 0 && $urandom_range(3, 0) == 0) begin
                        push(d, c, $urandom_range(4, 1), 8'($urandom));
                    end
                end
                ordy[d] = ($urandom_range(3, 0) != 0);
            end
            drive();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
